wavegen_axil_regs: RTL

AXI4-Lite slave register file that terminates the control path driven by the PS/VIP master into the wavegen IP. It accepts single-beat writes and reads on four 32-bit registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It exposes the register contents plus per-register write strobes to the waveform datapath. Register readback must return exactly the last value written, e.g. 1, 2, 3, 4 after a sequential write of those values.

---
 rtl/wavegen_axil_regs.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wavegen_axil_regs.sv
// AXI4-Lite slave: four 32-bit control registers for the wavegen datapath.
// Ports: s00_axi_* AXI4-Lite slave, slv_reg0..3 contents, reg_wr_pulse strobes.
module wavegen_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          aw_full;
  logic [1:0]                    aw_idx;
  logic                          w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]                 w_strb;
  logic                          bvalid_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [3:0]                    pulse_q;
  logic                          commit;
  logic [C_S_AXI_DATA_WIDTH-1:0] merged;

  // Address LSBs and protection bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Ready signals come only from flops; a pending B blocks new writes.
  assign s00_axi_awready = !aw_full && !bvalid_q;
  assign s00_axi_wready  = !w_full && !bvalid_q;
  assign s00_axi_arready = !rvalid_q;

  assign commit = aw_full && w_full && !bvalid_q;

  always_comb begin
    merged = regs[aw_idx];
    for (int b = 0; b < NB; b++) begin
      if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      pulse_q  <= '0;
    end else begin
      pulse_q <= '0;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[3:2];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (commit) begin
        regs[aw_idx]    <= merged;
        aw_full         <= 1'b0;
        w_full          <= 1'b0;
        bvalid_q        <= 1'b1;
        pulse_q[aw_idx] <= |w_strb;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // A read on the commit edge samples regs before the update lands.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[s00_axi_araddr[3:2]];
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign slv_reg0       = regs[0];
  assign slv_reg1       = regs[1];
  assign slv_reg2       = regs[2];
  assign slv_reg3       = regs[3];
  assign reg_wr_pulse   = pulse_q;

endmodule
